// File: rtl/pcie_perst_pkg.sv
// Shared types and defaults for the PERST# conditioner.
// Counter widths are derived in the top from the largest timing parameter.
package pcie_perst_pkg;

    typedef enum logic [2:0] {
        HOLD,
        QUAL_HI,
        RELEASE,
        RUN,
        QUAL_LO
    } perst_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES      = 1024;
    localparam int unsigned DEF_ASSERT_FILTER_CYCLES = 4;
    localparam int unsigned DEF_MIN_ASSERT_CYCLES    = 10000;
    localparam int unsigned DEF_RELEASE_DELAY_CYCLES = 256;

    localparam int unsigned EVT_CNT_W = 8;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer; output lags the input by two clock edges.
// Both stages clear to 0 on the asynchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pcie_perst_conditioner.sv
// Turns the raw PERST# pin into a clean, registered active-low reset with glitch
// filtering, a minimum assertion time and a release delay, plus debug counters.
module pcie_perst_conditioner
    import pcie_perst_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned ASSERT_FILTER_CYCLES = DEF_ASSERT_FILTER_CYCLES,
    parameter int unsigned MIN_ASSERT_CYCLES    = DEF_MIN_ASSERT_CYCLES,
    parameter int unsigned RELEASE_DELAY_CYCLES = DEF_RELEASE_DELAY_CYCLES
) (
    input  logic                 pcie_ref_clk,
    input  logic                 mig_reset,
    input  logic                 pcie_rst_n_pin,
    output logic                 pcie_rst_n,
    output logic                 perst_active,
    output logic [EVT_CNT_W-1:0] perst_event_count,
    output logic [EVT_CNT_W-1:0] glitch_count
);

    localparam int unsigned MAXP = max4(DEBOUNCE_CYCLES, ASSERT_FILTER_CYCLES,
                                        MIN_ASSERT_CYCLES, RELEASE_DELAY_CYCLES);
    localparam int unsigned CW   = $clog2(MAXP + 1);

    localparam logic [CW-1:0] DEB_C      = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] AF_C       = CW'(ASSERT_FILTER_CYCLES);
    localparam logic [CW-1:0] MIN_C      = CW'(MIN_ASSERT_CYCLES);
    localparam logic [CW-1:0] REL_LAST_C = CW'(RELEASE_DELAY_CYCLES - 1);
    localparam logic [CW-1:0] ONE_C      = CW'(1);
    localparam logic [EVT_CNT_W-1:0] EVT_MAX = '1;

    logic pin_s;

    sync_2ff u_sync (
        .clk (pcie_ref_clk),
        .rst (mig_reset),
        .d   (pcie_rst_n_pin),
        .q   (pin_s)
    );

    perst_state_t         state_q, state_d;
    logic [CW-1:0]        hold_q, hold_d;
    logic [CW-1:0]        deb_q, deb_d;
    logic [CW-1:0]        rel_q, rel_d;
    logic [EVT_CNT_W-1:0] evt_q, evt_d;
    logic [EVT_CNT_W-1:0] glitch_q, glitch_d;
    logic                 rst_n_q, rst_n_d;

    logic [CW-1:0]        hold_inc;
    logic [CW-1:0]        deb_plus;
    logic [CW-1:0]        deb_hi_nxt;
    logic [EVT_CNT_W-1:0] glitch_inc;
    logic [EVT_CNT_W-1:0] evt_inc;

    always_comb begin
        hold_inc   = (hold_q == MIN_C) ? hold_q : hold_q + ONE_C;
        deb_plus   = deb_q + ONE_C;
        deb_hi_nxt = (deb_q == DEB_C) ? deb_q : deb_plus;
        glitch_inc = (glitch_q == EVT_MAX) ? glitch_q : glitch_q + 1'b1;
        evt_inc    = (evt_q == EVT_MAX) ? evt_q : evt_q + 1'b1;

        state_d  = state_q;
        hold_d   = hold_q;
        deb_d    = deb_q;
        rel_d    = rel_q;
        evt_d    = evt_q;
        glitch_d = glitch_q;
        rst_n_d  = (state_q == RUN) || (state_q == QUAL_LO);

        // The debounce and assert-filter thresholds are judged on the count that
        // includes the current sample, so a completed window transitions at once.
        unique case (state_q)
            HOLD: begin
                hold_d = hold_inc;
                if (pin_s) begin
                    state_d = QUAL_HI;
                    deb_d   = ONE_C;
                end
            end
            QUAL_HI: begin
                hold_d = hold_inc;
                if (!pin_s) begin
                    glitch_d = glitch_inc;
                    state_d  = HOLD;
                end else begin
                    deb_d = deb_hi_nxt;
                    if ((deb_hi_nxt == DEB_C) && (hold_inc == MIN_C)) begin
                        state_d = RELEASE;
                        rel_d   = '0;
                    end
                end
            end
            RELEASE: begin
                hold_d = hold_inc;
                rel_d  = rel_q + ONE_C;
                if (!pin_s) begin
                    glitch_d = glitch_inc;
                    state_d  = HOLD;
                end else if (rel_q == REL_LAST_C) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!pin_s) begin
                    state_d = QUAL_LO;
                    deb_d   = ONE_C;
                end
            end
            QUAL_LO: begin
                if (pin_s) begin
                    glitch_d = glitch_inc;
                    state_d  = RUN;
                end else begin
                    deb_d = deb_plus;
                    if (deb_plus >= AF_C) begin
                        state_d = HOLD;
                        hold_d  = '0;
                        evt_d   = evt_inc;
                    end
                end
            end
            default: state_d = HOLD;
        endcase
    end

    always_ff @(posedge pcie_ref_clk or posedge mig_reset) begin
        if (mig_reset) begin
            state_q  <= HOLD;
            hold_q   <= '0;
            deb_q    <= '0;
            rel_q    <= '0;
            evt_q    <= '0;
            glitch_q <= '0;
            rst_n_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            deb_q    <= deb_d;
            rel_q    <= rel_d;
            evt_q    <= evt_d;
            glitch_q <= glitch_d;
            rst_n_q  <= rst_n_d;
        end
    end

    assign pcie_rst_n        = rst_n_q;
    assign perst_active      = ~rst_n_q;
    assign perst_event_count = evt_q;
    assign glitch_count      = glitch_q;

endmodule

// File: tb/tb_pcie_perst_conditioner.sv
// Directed bench for the PERST# conditioner with shortened timing parameters.
module tb_pcie_perst_conditioner;
    import pcie_perst_pkg::*;

    logic       pcie_ref_clk = 1'b0;
    logic       mig_reset;
    logic       pin;
    logic       pcie_rst_n;
    logic       perst_active;
    logic [7:0] perst_event_count;
    logic [7:0] glitch_count;

    int checks = 0;
    int errors = 0;

    pcie_perst_conditioner #(
        .DEBOUNCE_CYCLES      (8),
        .ASSERT_FILTER_CYCLES (2),
        .MIN_ASSERT_CYCLES    (32),
        .RELEASE_DELAY_CYCLES (4)
    ) dut (
        .pcie_ref_clk      (pcie_ref_clk),
        .mig_reset         (mig_reset),
        .pcie_rst_n_pin    (pin),
        .pcie_rst_n        (pcie_rst_n),
        .perst_active      (perst_active),
        .perst_event_count (perst_event_count),
        .glitch_count      (glitch_count)
    );

    always #5 pcie_ref_clk = ~pcie_ref_clk;

    task automatic step(input int n);
        repeat (n) @(posedge pcie_ref_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pin low for 40 cycles then high for 20: one accepted assertion and a full release.
    task automatic assert_cycle();
        pin = 1'b0;
        step(40);
        pin = 1'b1;
        step(20);
    endtask

    initial begin
        mig_reset = 1'b1;
        pin       = 1'b1;
        step(3);
        chk("reset_rst_n", {7'd0, pcie_rst_n}, 8'd0);
        chk("reset_active", {7'd0, perst_active}, 8'd1);
        chk("reset_evt", perst_event_count, 8'd0);
        chk("reset_glitch", glitch_count, 8'd0);
        chk("reset_state", 8'(dut.state_q), 8'(HOLD));

        // First release: pin high throughout, limited by the 32-cycle minimum.
        mig_reset = 1'b0;
        step(36);
        chk("first_rel_before", {7'd0, pcie_rst_n}, 8'd0);
        step(1);
        chk("first_rel_at37", {7'd0, pcie_rst_n}, 8'd1);
        chk("first_rel_active", {7'd0, perst_active}, 8'd0);
        chk("first_rel_evt", perst_event_count, 8'd0);
        chk("first_rel_glitch", glitch_count, 8'd0);

        // One-cycle low pulse while running.
        pin = 1'b0;
        step(1);
        pin = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("pulse_rst_n_held", {7'd0, pcie_rst_n}, 8'd1);
            step(1);
        end
        chk("pulse_glitch", glitch_count, 8'd1);
        chk("pulse_evt", perst_event_count, 8'd0);

        // Pin low 20 cycles: assert at +5, release held off by the minimum (edge 41).
        pin = 1'b0;
        step(4);
        chk("assert_before5", {7'd0, pcie_rst_n}, 8'd1);
        step(1);
        chk("assert_at5", {7'd0, pcie_rst_n}, 8'd0);
        chk("assert_evt", perst_event_count, 8'd1);
        step(15);
        pin = 1'b1;
        step(20);
        chk("minhold_at40", {7'd0, pcie_rst_n}, 8'd0);
        step(1);
        chk("minhold_rel41", {7'd0, pcie_rst_n}, 8'd1);
        chk("minhold_glitch", glitch_count, 8'd1);

        // Drop during debounce at deb_cnt=5, then restart the debounce from 1.
        pin = 1'b0;
        step(40);
        pin = 1'b1;
        step(5);
        pin = 1'b0;
        step(1);
        pin = 1'b1;
        step(1);
        chk("qualhi_glitch_pre", glitch_count, 8'd1);
        chk("qualhi_state_pre", 8'(dut.state_q), 8'(QUAL_HI));
        step(1);
        chk("qualhi_glitch", glitch_count, 8'd2);
        chk("qualhi_back_hold", 8'(dut.state_q), 8'(HOLD));
        step(12);
        chk("qualhi_restart_at60", {7'd0, pcie_rst_n}, 8'd0);
        step(1);
        chk("qualhi_restart_at61", {7'd0, pcie_rst_n}, 8'd1);
        chk("qualhi_evt", perst_event_count, 8'd2);

        // Drive the event counter through saturation: 300 accepted assertions in total.
        for (int i = 0; i < 252; i++) assert_cycle();
        chk("evt_254", perst_event_count, 8'd254);
        assert_cycle();
        chk("evt_255", perst_event_count, 8'd255);
        for (int i = 0; i < 45; i++) assert_cycle();
        chk("evt_sat", perst_event_count, 8'd255);
        chk("evt_sat_rst_n", {7'd0, pcie_rst_n}, 8'd1);
        chk("evt_sat_glitch", glitch_count, 8'd2);

        // Reset pulsed while in RELEASE.
        pin = 1'b0;
        step(40);
        pin = 1'b1;
        step(12);
        chk("rel_state", 8'(dut.state_q), 8'(RELEASE));
        chk("rel_rst_n", {7'd0, pcie_rst_n}, 8'd0);
        mig_reset = 1'b1;
        #1;
        chk("abort_rst_n", {7'd0, pcie_rst_n}, 8'd0);
        chk("abort_active", {7'd0, perst_active}, 8'd1);
        chk("abort_evt", perst_event_count, 8'd0);
        chk("abort_glitch", glitch_count, 8'd0);
        chk("abort_state", 8'(dut.state_q), 8'(HOLD));
        step(2);
        mig_reset = 1'b0;
        step(36);
        chk("after_abort_before", {7'd0, pcie_rst_n}, 8'd0);
        step(1);
        chk("after_abort_rel", {7'd0, pcie_rst_n}, 8'd1);
        chk("after_abort_evt", perst_event_count, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
